// File: rtl/input_v_bank_scheduler_if.sv
// Bus bundle between the input-voltage bank scheduler and its exchange/solver neighbours.
// With INPUT_V_OVR_CNT_EN defined, the bundle also carries the dropped-request counter ovr_cnt.
interface input_v_bank_scheduler_if #(
   parameter int unsigned AddrW = 4
);
   logic             sta;
   logic             exchange_data_sig;
   logic             err_clr;
   logic [AddrW:0]   wr_addr;
   logic             wr_en;
   logic [AddrW:0]   rd_addr;
   logic             rd_en;
   logic             mem_ena;
   logic             rd_valid;
   logic [AddrW-1:0] rd_idx;
   logic             done_sig;
   logic             act_bank;
   logic             busy_wr;
   logic             busy_rd;
   logic             ovr_err;
`ifdef INPUT_V_OVR_CNT_EN
   logic [7:0]       ovr_cnt;
`endif

   modport slave (
      input  sta, exchange_data_sig, err_clr,
      output wr_addr, wr_en, rd_addr, rd_en, mem_ena, rd_valid, rd_idx, done_sig,
      output act_bank, busy_wr, busy_rd, ovr_err
`ifdef INPUT_V_OVR_CNT_EN
      , output ovr_cnt
`endif
   );

   modport master (
      output sta, exchange_data_sig, err_clr,
      input  wr_addr, wr_en, rd_addr, rd_en, mem_ena, rd_valid, rd_idx, done_sig,
      input  act_bank, busy_wr, busy_rd, ovr_err
`ifdef INPUT_V_OVR_CNT_EN
      , input ovr_cnt
`endif
   );
endinterface

// File: rtl/input_v_bank_scheduler.sv
// Double-buffered input-voltage RAM sequencer: writer fills the inactive bank, reader drains the
// active one, banks swap only when the reader is idle. INPUT_V_OVR_CNT_EN adds a drop counter.
module input_v_bank_scheduler #(
   parameter int unsigned AddrW      = 4,
   parameter int unsigned NWords     = 13,
   parameter int unsigned RdLat      = 2,
   parameter int unsigned WrStartDly = 2
) (
   input logic                        clk_i,
   input logic                        rst_ni,
   input_v_bank_scheduler_if.slave    bus
);
   localparam int unsigned DlyW = (WrStartDly > 2) ? $clog2(WrStartDly - 1) : 1;
   localparam int unsigned LatW = (RdLat > 1) ? $clog2(RdLat) : 1;
   localparam logic [AddrW-1:0] LastIdx = AddrW'(NWords - 1);
   localparam logic [DlyW-1:0]  LastDly = (WrStartDly > 2) ? DlyW'(WrStartDly - 2) : '0;
   localparam logic [LatW-1:0]  LastLat = LatW'(RdLat - 1);

   typedef enum logic [1:0] {WIdle, WDly, WRun, WPend} w_state_e;
   typedef enum logic [1:0] {RIdle, RRun, RDrain} r_state_e;

   w_state_e         w_state_q, w_state_d;
   r_state_e         r_state_q, r_state_d;
   logic [AddrW-1:0] wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
   logic [DlyW-1:0]  dly_cnt_q, dly_cnt_d;
   logic [LatW-1:0]  lat_cnt_q, lat_cnt_d;
   logic             act_bank_q, act_bank_d;
   logic             done_q, done_d;
   logic             ovr_err_q, ovr_err_d;
   logic [RdLat-1:0] vld_q;
   logic [AddrW-1:0] vidx_q [RdLat];
   logic             wr_en, rd_en, wr_busy, rd_busy, swap, wr_drop, rd_drop;
`ifdef INPUT_V_OVR_CNT_EN
   logic [7:0]       ovr_cnt_q, ovr_cnt_d;
   logic [8:0]       cnt_sum;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         w_state_q  <= WIdle;
         r_state_q  <= RIdle;
         wr_idx_q   <= '0;
         rd_idx_q   <= '0;
         dly_cnt_q  <= '0;
         lat_cnt_q  <= '0;
         act_bank_q <= 1'b0;
         done_q     <= 1'b0;
         ovr_err_q  <= 1'b0;
         vld_q      <= '0;
         for (int unsigned i = 0; i < RdLat; i++) vidx_q[i] <= '0;
`ifdef INPUT_V_OVR_CNT_EN
         ovr_cnt_q  <= '0;
`endif
      end else begin
         w_state_q  <= w_state_d;
         r_state_q  <= r_state_d;
         wr_idx_q   <= wr_idx_d;
         rd_idx_q   <= rd_idx_d;
         dly_cnt_q  <= dly_cnt_d;
         lat_cnt_q  <= lat_cnt_d;
         act_bank_q <= act_bank_d;
         done_q     <= done_d;
         ovr_err_q  <= ovr_err_d;
         vld_q[0]   <= rd_en;
         vidx_q[0]  <= rd_idx_q;
         for (int unsigned i = 1; i < RdLat; i++) begin
            vld_q[i]  <= vld_q[i-1];
            vidx_q[i] <= vidx_q[i-1];
         end
`ifdef INPUT_V_OVR_CNT_EN
         ovr_cnt_q  <= ovr_cnt_d;
`endif
      end
   end

   always_comb begin
      wr_busy    = (w_state_q == WDly) || (w_state_q == WRun);
      rd_busy    = (r_state_q == RRun) || (r_state_q == RDrain);
      // Bank ownership changes hands only while the reader is completely idle.
      swap       = (w_state_q == WPend) && (r_state_q == RIdle);
      wr_drop    = bus.exchange_data_sig && wr_busy;
      rd_drop    = bus.sta && rd_busy;
      w_state_d  = w_state_q;
      r_state_d  = r_state_q;
      wr_idx_d   = wr_idx_q;
      rd_idx_d   = rd_idx_q;
      dly_cnt_d  = dly_cnt_q;
      lat_cnt_d  = lat_cnt_q;
      done_d     = 1'b0;
      act_bank_d = act_bank_q ^ swap;

      unique case (w_state_q)
         WIdle, WPend: begin
            // The request cycle counts as the first delay cycle.
            if (bus.exchange_data_sig) begin
               wr_idx_d  = '0;
               dly_cnt_d = '0;
               w_state_d = (WrStartDly > 1) ? WDly : WRun;
            end else if (swap) begin
               w_state_d = WIdle;
            end
         end
         WDly: begin
            if (dly_cnt_q == LastDly) w_state_d = WRun;
            else                      dly_cnt_d = dly_cnt_q + 1'b1;
         end
         WRun: begin
            if (wr_idx_q == LastIdx) begin
               w_state_d = WPend;
               wr_idx_d  = '0;
            end else begin
               wr_idx_d  = wr_idx_q + 1'b1;
            end
         end
         default: w_state_d = WIdle;
      endcase

      unique case (r_state_q)
         RIdle: begin
            if (bus.sta) begin
               r_state_d = RRun;
               rd_idx_d  = '0;
            end
         end
         RRun: begin
            if (rd_idx_q == LastIdx) begin
               r_state_d = RDrain;
               rd_idx_d  = '0;
               lat_cnt_d = '0;
            end else begin
               rd_idx_d  = rd_idx_q + 1'b1;
            end
         end
         RDrain: begin
            if (lat_cnt_q == LastLat) begin
               r_state_d = RIdle;
               done_d    = 1'b1;
            end else begin
               lat_cnt_d = lat_cnt_q + 1'b1;
            end
         end
         default: r_state_d = RIdle;
      endcase

      if (bus.err_clr)             ovr_err_d = 1'b0;
      else if (wr_drop || rd_drop) ovr_err_d = 1'b1;
      else                         ovr_err_d = ovr_err_q;
`ifdef INPUT_V_OVR_CNT_EN
      cnt_sum   = {1'b0, ovr_cnt_q} + 9'(wr_drop) + 9'(rd_drop);
      ovr_cnt_d = bus.err_clr ? 8'h00 : ((cnt_sum > 9'd255) ? 8'hFF : cnt_sum[7:0]);
`endif
   end

   always_comb begin
      wr_en            = (w_state_q == WRun);
      rd_en            = (r_state_q == RRun);
      bus.wr_en        = wr_en;
      bus.rd_en        = rd_en;
      bus.mem_ena      = wr_en || rd_en;
      bus.wr_addr      = wr_en ? {~act_bank_q, wr_idx_q} : '0;
      bus.rd_addr      = rd_en ? {act_bank_q, rd_idx_q} : '0;
      bus.rd_valid     = vld_q[RdLat-1];
      bus.rd_idx       = vidx_q[RdLat-1];
      bus.done_sig     = done_q;
      bus.act_bank     = act_bank_q;
      bus.busy_wr      = (w_state_q == WDly) || (w_state_q == WRun);
      bus.busy_rd      = (r_state_q == RRun) || (r_state_q == RDrain);
      bus.ovr_err      = ovr_err_q;
`ifdef INPUT_V_OVR_CNT_EN
      bus.ovr_cnt      = ovr_cnt_q;
`endif
   end
endmodule
